i2c_bus_arbiter: RTL
====================

// Module: i2c_bus_arbiter
// PURPOSE
//  Shares the single I2C master (ena/addr/sub_addr/data_wr/data_rd/busy/ack_err)
//  among NUM_REQ sensor controllers (altimeter, accelerometer, ...).
//  Round-robin arbitration; one single-byte register transaction per grant.
//  Sequences the master's ena/busy handshake, returns read data and error status,
//  and bounds every transaction with a watchdog timeout.
// PARAMETERS
//  NUM_REQ         4      number of requesters (2..8)
//  TIMEOUT_CYCLES  50000  max cycles in ISSUE or XFER before forced abort (>=2)
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  rst           in   1          synchronous, active-high reset
//  req           in   NUM_REQ    per-requester request, held until its done pulse
//  req_addr      in   8*NUM_REQ  slave addr incl. R/W bit; slice i = [8i+7:8i]
//  req_sub_addr  in   8*NUM_REQ  register address, same slicing
//  req_data_wr   in   8*NUM_REQ  write byte, same slicing
//  grant         out  NUM_REQ    one-hot owner, valid ISSUE..DONE, else 0
//  done          out  NUM_REQ    1-cycle completion pulse to the owner
//  rd_data       out  8          captured read byte, valid while done!=0
//  err           out  1          ack_err or timeout, valid while done!=0
//  timeout       out  1          abort cause was watchdog, valid while done!=0
//  ena           out  1          I2C master enable
//  addr          out  8          to master, latched from owner
//  sub_addr      out  8          to master, latched from owner
//  data_wr       out  8          to master, latched from owner
//  data_rd       in   8          from master
//  busy          in   1          from master, high while transaction runs
//  ack_err       in   1          from master, slave NACK flag
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, wdog 0, last_grant = NUM_REQ-1 (req 0 wins first).
//  rst overrides everything incl. mid-transaction; no done pulse for aborted owner.
//  States: IDLE -> ISSUE -> XFER -> DONE -> IDLE.
//  IDLE: ena=0, grant=0. If |req && !busy: pick first set req scanning
//   last_grant+1, +2, ... (mod NUM_REQ); latch its addr/sub_addr/data_wr,
//   set grant, ena<=1, -> ISSUE. busy high in IDLE blocks any grant.
//  ISSUE: ena=1. busy==1 -> ena<=0, -> XFER.
//  XFER: ena=0. busy==0 -> capture rd_data<=data_rd, err<=ack_err, -> DONE.
//  DONE: done[owner]=1 for exactly one cycle, grant held; last_grant<=owner;
//   -> IDLE; done, err, timeout, grant cleared on exit.
//  Latency: ena rises the cycle after req seen in IDLE; done rises 1 cycle after busy falls.
//  Min gap between grants: 1 IDLE cycle (next owner's ena 2 cycles after done).
//  Watchdog: counter cleared on entry to ISSUE and XFER, +1 per cycle there;
//   on reaching TIMEOUT_CYCLES-1: ena<=0, err<=1, timeout<=1, rd_data<=0, -> DONE.
//   Counter width $clog2(TIMEOUT_CYCLES); no wrap possible.
//  Simultaneous busy edge and timeout in same cycle: busy edge wins (normal path).
//  addr/sub_addr/data_wr stable from grant until next grant; req inputs ignored
//   except in IDLE. Dropping req mid-transaction does not abort; done still pulses.
//  Requester still holding req after done re-enters arbitration with lowest priority.
//  Requests on unused bits when NUM_REQ<8: n/a (no padding).
// TESTING
//  1 req=0001, addr0=0xEF sub0=0xF6; busy rises 3 cyc after ena, falls 20 cyc later
//    with data_rd=0x5A -> ena high exactly 4 cyc, done=0001 1 cyc, rd_data=0x5A, err=0.
//  2 req=0011 held continuously, master model answers each -> grant order 0,1,0,1;
//    addr output switches to owner's value on each grant.
//  3 ack_err=1 at busy fall, data_rd=0xFF -> done pulse with err=1, timeout=0.
//  4 TIMEOUT_CYCLES=100, busy never rises -> ena drops after 100 ISSUE cycles,
//    done=0001 with err=1, timeout=1, rd_data=0x00, then IDLE.
//  5 rst pulsed mid-XFER (busy still 1) -> next cycle all outputs 0; after release,
//    req=0001 pending but no ena until busy goes 0, then requester 0 granted.
//  6 req[2] dropped during XFER -> transaction completes, done=0100 still pulsed,
//    next IDLE grants another pending requester, not 2.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C byte-register master among NUM_REQ requesters.
// One transaction per grant; the ena/busy handshake is bounded by a watchdog.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_sub_addr,
    input  logic [8*NUM_REQ-1:0] req_data_wr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rd_data,
    output logic                 err,
    output logic                 timeout,
    output logic                 ena,
    output logic [7:0]           addr,
    output logic [7:0]           sub_addr,
    output logic [7:0]           data_wr,
    input  logic [7:0]           data_rd,
    input  logic                 busy,
    input  logic                 ack_err
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   owner;
    logic [WD_W-1:0] wdog;
    logic            wdog_expired;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_idx;
    int              scan_pos;

    assign wdog_expired = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Scan from farthest to nearest so the candidate closest after last_grant wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_pos = 0;
        scan_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_pos = int'(last_grant) + k;
            if (scan_pos >= NUM_REQ)
                scan_pos = scan_pos - NUM_REQ;
            scan_idx = IW'(scan_pos);
            if (req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            owner      <= '0;
            wdog       <= '0;
            grant      <= '0;
            done       <= '0;
            rd_data    <= '0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            ena        <= 1'b0;
            addr       <= '0;
            sub_addr   <= '0;
            data_wr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ena   <= 1'b0;
                    grant <= '0;
                    if (pick_vld && !busy) begin
                        owner    <= pick_idx;
                        grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        addr     <= req_addr[{pick_idx, 3'b000} +: 8];
                        sub_addr <= req_sub_addr[{pick_idx, 3'b000} +: 8];
                        data_wr  <= req_data_wr[{pick_idx, 3'b000} +: 8];
                        ena      <= 1'b1;
                        wdog     <= '0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (busy) begin
                        ena   <= 1'b0;
                        wdog  <= '0;
                        state <= S_XFER;
                    end else if (wdog_expired) begin
                        ena     <= 1'b0;
                        err     <= 1'b1;
                        timeout <= 1'b1;
                        rd_data <= '0;
                        done    <= grant;
                        state   <= S_DONE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                S_XFER: begin
                    ena <= 1'b0;
                    // A busy fall in the expiry cycle still completes normally.
                    if (!busy) begin
                        rd_data <= data_rd;
                        err     <= ack_err;
                        timeout <= 1'b0;
                        done    <= grant;
                        state   <= S_DONE;
                    end else if (wdog_expired) begin
                        err     <= 1'b1;
                        timeout <= 1'b1;
                        rd_data <= '0;
                        done    <= grant;
                        state   <= S_DONE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                S_DONE: begin
                    done       <= '0;
                    err        <= 1'b0;
                    timeout    <= 1'b0;
                    grant      <= '0;
                    last_grant <= owner;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
